csa_resolve_seq: RTL



---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_chunk_adder.sv | 22 ++
 rtl/csa_resolve_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared state type, sizing helper and default widths for the CSA resolver
package csa_pkg;

    localparam int CSA_WIDTH = 25;
    localparam int CSA_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } csa_state_t;

    // Number of CHUNK-bit slices needed to cover a WIDTH-bit operand.
    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// rtl/csa_chunk_adder.sv - combinational W-bit adder with carry in and carry out
module csa_chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    // Widen by one bit so the carry out falls into the top position.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign sum  = total[W-1:0];
    assign cout = total[W];

endmodule

// File: rtl/csa_resolve_seq.sv
// rtl/csa_resolve_seq.sv - multi-cycle carry-propagate resolver for a carry-save pair
module csa_resolve_seq
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);

    localparam int NCHUNK   = nchunk(WIDTH, CHUNK);
    localparam int IDX_W    = $clog2(NCHUNK) + 1;
    // Live bits in the top chunk; the carry into bit WIDTH sits just above them.
    localparam int TOP_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    csa_state_t       state_q;
    csa_state_t       state_d;
    logic [WIDTH-1:0] op_sum_q;
    logic [WIDTH-1:0] op_carry_q;
    logic [WIDTH-1:0] result_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             cout_q;

    int               base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] chunk_mask;
    logic [WIDTH-1:0] chunk_placed;
    logic [WIDTH-1:0] result_merged;
    logic             top_carry;
    logic             last_chunk;
    logic             accept;

    assign accept     = (state_q == IDLE) && in_valid;
    assign last_chunk = (idx_q == LAST_IDX);

    // Select the current chunk of each operand; shifting past WIDTH pads with zeros.
    always_comb begin
        base    = int'(idx_q) * CHUNK;
        chunk_a = CHUNK'(op_sum_q >> base);
        chunk_b = CHUNK'(op_carry_q >> base);
    end

    csa_chunk_adder #(
        .W (CHUNK)
    ) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Splice the chunk sum into the result; bits that land at or above WIDTH drop off.
    always_comb begin
        chunk_mask    = WIDTH'({{WIDTH{1'b0}}, {CHUNK{1'b1}}} << base);
        chunk_placed  = WIDTH'({{WIDTH{1'b0}}, chunk_sum} << base);
        result_merged = (result_q & ~chunk_mask) | chunk_placed;
        top_carry     = |({chunk_cout, chunk_sum} & ((CHUNK + 1)'(1) << TOP_BITS));
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one chunk resolved per BUSY cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_sum_q   <= '0;
            op_carry_q <= '0;
            result_q   <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
        end else if (accept) begin
            op_sum_q   <= in_sum;
            op_carry_q <= in_carry;
            idx_q      <= '0;
            carry_q    <= 1'b0;
        end else if (state_q == BUSY) begin
            result_q <= result_merged;
            carry_q  <= chunk_cout;
            idx_q    <= idx_q + IDX_W'(1);
            if (last_chunk) begin
                cout_q <= top_carry;
            end
        end
    end

    assign out_result = result_q;
    assign out_cout   = cout_q;

endmodule
